// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse cursor tracker.
// Holds the packet-assembly FSM state type, the bit positions inside status
// byte 0 of a PS/2 mouse packet, and the default parameter values.
package ps2_mouse_pkg;

  typedef enum logic [1:0] {
    StWaitB0,
    StWaitB1,
    StWaitB2
  } pkt_state_e;

  // Status byte (byte 0) layout
  localparam int unsigned BtnLeftBit   = 0;
  localparam int unsigned BtnRightBit  = 1;
  localparam int unsigned BtnMiddleBit = 2;
  localparam int unsigned SyncBit      = 3;
  localparam int unsigned XSignBit     = 4;
  localparam int unsigned YSignBit     = 5;
  localparam int unsigned XOvfBit      = 6;
  localparam int unsigned YOvfBit      = 7;

  // Default parameter values
  localparam int unsigned DefXWidth        = 10;
  localparam int unsigned DefYWidth        = 10;
  localparam int unsigned DefXMax          = 639;
  localparam int unsigned DefYMax          = 479;
  localparam int unsigned DefScaleShift    = 0;
  localparam int unsigned DefFifoDepth     = 4;
  localparam int unsigned DefTimeoutCycles = 200000;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event buffer.
// Ports:
//   clk_i / clear_i      clock, synchronous active-high clear
//   wr_en_i / wr_data_i  write request; taken when not full, or when full with a pop
//   rd_en_i              pop request; ignored while empty
//   rd_data_o            head entry, valid while empty_o is low
//   full_o / empty_o     occupancy flags
module ps2_event_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 26
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             wr_fire, rd_fire;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign rd_fire   = rd_en_i & ~empty_o;
  assign wr_fire   = wr_en_i & (~full_o | rd_fire);
  assign rd_data_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + (AddrW + 1)'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + (AddrW + 1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/ps2_mouse_cursor_tracker.sv
// PS/2 mouse cursor tracker.
// Assembles 3-byte PS/2 mouse packets, moves a saturating cursor and queues an
// event whenever the position or the button state changes.
// Ports:
//   Clock_100MHz, Clear            clock, synchronous active-high reset
//   Byte_in, Byte_valid            received byte and its one-cycle strobe
//   Cursor_X, Cursor_Y             live cursor position
//   Event_valid/ready              FWFT event stream handshake
//   Event_X/Y/buttons/changed      head event contents
//   Sync_error, Overflow_drop      one-cycle status pulses
module ps2_mouse_cursor_tracker
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned X_WIDTH        = DefXWidth,
  parameter int unsigned Y_WIDTH        = DefYWidth,
  parameter int unsigned X_MAX          = DefXMax,
  parameter int unsigned Y_MAX          = DefYMax,
  parameter int unsigned SCALE_SHIFT    = DefScaleShift,
  parameter int unsigned FIFO_DEPTH     = DefFifoDepth,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic               Clock_100MHz,
  input  logic               Clear,
  input  logic [7:0]         Byte_in,
  input  logic               Byte_valid,
  output logic [X_WIDTH-1:0] Cursor_X,
  output logic [Y_WIDTH-1:0] Cursor_Y,
  output logic               Event_valid,
  input  logic               Event_ready,
  output logic [X_WIDTH-1:0] Event_X,
  output logic [Y_WIDTH-1:0] Event_Y,
  output logic [2:0]         Event_buttons,
  output logic [2:0]         Event_changed,
  output logic               Sync_error,
  output logic               Overflow_drop
);

  localparam int unsigned GapW   = $clog2(TIMEOUT_CYCLES + 1);
  // Room for position, 9-bit signed delta after shifting, and a sign bit.
  localparam int unsigned SumW   = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + SCALE_SHIFT + 11;
  localparam int unsigned EntryW = X_WIDTH + Y_WIDTH + 6;

  pkt_state_e         state_q, state_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [7:0]         b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic               pkt_done_q, pkt_done_d;
  logic               sync_err_q, sync_err_d;
  logic               drop_q, drop_d;
  logic [X_WIDTH-1:0] cursor_x_q, cursor_x_d;
  logic [Y_WIDTH-1:0] cursor_y_q, cursor_y_d;
  logic [2:0]         buttons_q, buttons_d;

  logic signed [8:0]      dx, dy;
  logic signed [SumW-1:0] dx_w, dy_w, x_sum, y_sum;
  logic [X_WIDTH-1:0]     x_new;
  logic [Y_WIDTH-1:0]     y_new;
  logic [2:0]             btn_new;
  logic                   fifo_wr, fifo_full, fifo_empty, fifo_pop;
  logic [EntryW-1:0]      fifo_wdata, fifo_rdata;

  // Packet assembly
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    pkt_done_d = 1'b0;
    sync_err_d = 1'b0;
    unique case (state_q)
      StWaitB0: begin
        gap_d = '0;
        if (Byte_valid) begin
          if (Byte_in[SyncBit]) begin
            b0_d    = Byte_in;
            state_d = StWaitB1;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      StWaitB1, StWaitB2: begin
        if (Byte_valid) begin
          gap_d = '0;
          if (state_q == StWaitB1) begin
            b1_d    = Byte_in;
            state_d = StWaitB2;
          end else begin
            b2_d       = Byte_in;
            pkt_done_d = b0_q[SyncBit];
            state_d    = StWaitB0;
          end
        end else if (gap_q == GapW'(TIMEOUT_CYCLES - 1)) begin
          // Stalled mid-packet: drop partial bytes and resync on the next byte 0.
          gap_d   = '0;
          state_d = StWaitB0;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StWaitB0;
    endcase
  end

  // Cursor arithmetic on the captured packet
  always_comb begin
    dx = b0_q[XOvfBit] ? 9'sd0 : $signed({b0_q[XSignBit], b1_q});
    dy = b0_q[YOvfBit] ? 9'sd0 : $signed({b0_q[YSignBit], b2_q});
    dx_w  = SumW'(dx) <<< SCALE_SHIFT;
    dy_w  = SumW'(dy) <<< SCALE_SHIFT;
    x_sum = $signed(SumW'(cursor_x_q)) + dx_w;
    // Screen Y grows downward while mouse dy grows upward.
    y_sum = $signed(SumW'(cursor_y_q)) - dy_w;

    if (x_sum[SumW-1])                         x_new = '0;
    else if (x_sum > $signed(SumW'(X_MAX)))    x_new = X_WIDTH'(X_MAX);
    else                                       x_new = x_sum[X_WIDTH-1:0];

    if (y_sum[SumW-1])                         y_new = '0;
    else if (y_sum > $signed(SumW'(Y_MAX)))    y_new = Y_WIDTH'(Y_MAX);
    else                                       y_new = y_sum[Y_WIDTH-1:0];

    btn_new = {b0_q[BtnMiddleBit], b0_q[BtnRightBit], b0_q[BtnLeftBit]};
  end

  assign fifo_pop   = Event_valid & Event_ready;
  assign fifo_wdata = {x_new, y_new, btn_new, btn_new ^ buttons_q};

  always_comb begin
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    buttons_d  = buttons_q;
    fifo_wr    = 1'b0;
    drop_d     = 1'b0;
    if (pkt_done_q) begin
      cursor_x_d = x_new;
      cursor_y_d = y_new;
      buttons_d  = btn_new;
      if ((x_new != cursor_x_q) || (y_new != cursor_y_q) || (btn_new != buttons_q)) begin
        // A pop in the same cycle frees a slot, so only a blocked write is lost.
        if (fifo_full && !fifo_pop) drop_d  = 1'b1;
        else                        fifo_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock_100MHz) begin
    if (Clear) begin
      state_q    <= StWaitB0;
      gap_q      <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      pkt_done_q <= 1'b0;
      sync_err_q <= 1'b0;
      drop_q     <= 1'b0;
      cursor_x_q <= X_WIDTH'(X_MAX / 2);
      cursor_y_q <= Y_WIDTH'(Y_MAX / 2);
      buttons_q  <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      pkt_done_q <= pkt_done_d;
      sync_err_q <= sync_err_d;
      drop_q     <= drop_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      buttons_q  <= buttons_d;
    end
  end

  ps2_event_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EntryW)
  ) u_event_fifo (
    .clk_i     (Clock_100MHz),
    .clear_i   (Clear),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign Event_valid = ~fifo_empty;
  assign {Event_X, Event_Y, Event_buttons, Event_changed} = fifo_rdata;
  assign Cursor_X      = cursor_x_q;
  assign Cursor_Y      = cursor_y_q;
  assign Sync_error    = sync_err_q;
  assign Overflow_drop = drop_q;

endmodule
